// File: rtl/jt12_kon_gen.sv
// ---------------------------------------------------------------------------
// jt12_kon_gen
//
// Key-on state block for the FM operator pipeline. One key-on bit is kept per
// (channel, operator) slot in an indexed register file, so the channel count
// is a parameter rather than a side effect of a shift-ring length. When the
// slot sequencer presents a slot, the block returns (one clk_en cycle later)
// the slot's key-on level plus key-on / key-off edge strobes relative to the
// previous visit of the same slot.
//
// CSM (composite sine mode) key-on is applied to channel CSM_CH for exactly
// one full operator pass per timer-A overflow. CSM_EN=0 removes that logic.
//
// Parameters:
//   NUM_CH  number of channels, 1..8
//   CSM_CH  channel forced on by CSM, must be < NUM_CH
//   CSM_EN  1 keeps the CSM logic, 0 removes it
//
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   clk_en       clock enable; state only advances while high
//   keyon_op     key-on mask from a register write (bit0=S1 .. bit3=S4)
//   keyon_ch     channel targeted by the key-on write
//   up_keyon     key-on register write strobe
//   next_op      slot operator being sequenced (0=S1 1=S3 2=S2 3=S4)
//   next_ch      slot channel being sequenced
//   csm          CSM mode enable
//   overflow_A   timer A overflow pulse
//   keyon_I      registered key-on level of the slot presented last clk_en
//   kon_edge     that slot went 0->1 since its previous visit
//   koff_edge    that slot went 1->0 since its previous visit
// ---------------------------------------------------------------------------
module jt12_kon_gen #(
  parameter int NUM_CH = 6,
  parameter int CSM_CH = 2,
  parameter bit CSM_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clk_en,
  input  logic [3:0] keyon_op,
  input  logic [2:0] keyon_ch,
  input  logic       up_keyon,
  input  logic [1:0] next_op,
  input  logic [2:0] next_ch,
  input  logic       csm,
  input  logic       overflow_A,
  output logic       keyon_I,
  output logic       kon_edge,
  output logic       koff_edge
);

  localparam logic [2:0] CSM_CH_SEL = 3'(CSM_CH);

  // Register file, one nibble per channel indexed by physical operator S1..S4
  logic [NUM_CH-1:0][3:0] kon;
  // Level seen on the previous visit of each slot, used for edge detection
  logic [NUM_CH-1:0][3:0] prev;

  logic [1:0] op_sel;
  logic       slot_valid;
  logic       reg_bit;
  logic       prev_bit;
  logic       cur;
  logic       csm_force;

  // Sequencer order is S1,S3,S2,S4, so the two slot bits swap to give the
  // physical operator index.
  assign op_sel = {next_op[0], next_op[1]};

  // Slot read. Channels at or above NUM_CH match no entry, so they read as
  // zero for both the level and the previous level.
  always_comb begin
    slot_valid = 1'b0;
    reg_bit    = 1'b0;
    prev_bit   = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (next_ch == 3'(i)) begin
        slot_valid = 1'b1;
        reg_bit    = kon[i][op_sel];
        prev_bit   = prev[i][op_sel];
      end
    end
  end

  // The CSM force is kept out of the register file; it only ORs into the
  // level presented for this visit.
  assign cur = slot_valid & (reg_bit | csm_force);

  // Key-on register writes. Writes to channels outside the file match no
  // entry and are dropped. Because the read above uses the registered value,
  // a write to the slot being read shows up only on its next visit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kon <= '0;
    end else if (clk_en && up_keyon) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (keyon_ch == 3'(i)) kon[i] <= keyon_op;
      end
    end
  end

  // Remember the level of each visited slot for the next visit's edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev <= '0;
    end else if (clk_en) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (next_ch == 3'(i)) prev[i][op_sel] <= cur;
      end
    end
  end

  // Registered outputs; they hold while clk_en is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      keyon_I   <= 1'b0;
      kon_edge  <= 1'b0;
      koff_edge <= 1'b0;
    end else if (clk_en) begin
      keyon_I   <= cur;
      kon_edge  <= cur & ~prev_bit;
      koff_edge <= ~cur & prev_bit;
    end
  end

  if (CSM_EN) begin : g_csm
    // IDLE has no pass pending; ARMED is the pending flag waiting for the
    // S1 slot of CSM_CH; ACTIVE covers the CSM_CH pass up to its S4 slot.
    typedef enum logic [1:0] {
      CSM_IDLE   = 2'd0,
      CSM_ARMED  = 2'd1,
      CSM_ACTIVE = 2'd2
    } csm_state_t;

    csm_state_t state;
    csm_state_t state_nxt;
    logic       on_csm_ch;
    logic       at_first;
    logic       at_last;
    logic       force_int;

    assign on_csm_ch = (next_ch == CSM_CH_SEL);
    assign at_first  = on_csm_ch && (next_op == 2'd0);
    assign at_last   = on_csm_ch && (next_op == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= CSM_IDLE;
      else        state <= state_nxt;
    end

    // Dropping csm abandons any pending or running pass without waiting for
    // clk_en. Overflows while ARMED or ACTIVE are simply absorbed.
    always_comb begin
      state_nxt = state;
      if (!csm) begin
        state_nxt = CSM_IDLE;
      end else if (clk_en) begin
        case (state)
          CSM_IDLE:   if (overflow_A) state_nxt = CSM_ARMED;
          CSM_ARMED:  if (at_first)   state_nxt = CSM_ACTIVE;
          CSM_ACTIVE: if (at_last)    state_nxt = CSM_IDLE;
          default:                    state_nxt = CSM_IDLE;
        endcase
      end
    end

    // The entry slot is forced while still ARMED so the whole pass, S1
    // included, sees the force. Gating by csm clears it in the same cycle.
    always_comb begin
      force_int = 1'b0;
      if (csm) begin
        case (state)
          CSM_ARMED:  force_int = at_first;
          CSM_ACTIVE: force_int = on_csm_ch;
          default:    force_int = 1'b0;
        endcase
      end
    end

    assign csm_force = force_int;
  end else begin : g_no_csm
    assign csm_force = 1'b0;
  end

endmodule

// File: tb/tb_jt12_kon_gen.sv
// ---------------------------------------------------------------------------
// tb_jt12_kon_gen
//
// Bench for jt12_kon_gen. Two instances share all inputs: the default
// configuration (6 channels) and a 3-channel one, so writes and slots above
// the channel count can be exercised. A behavioural model produces the
// expected outputs of both instances for every enabled cycle; they are queued
// when the slot is driven and popped when the registered outputs appear.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_jt12_kon_gen;

  localparam int MODEL_CSM_CH = 2;

  typedef struct packed {
    logic [2:0] a;
    logic [2:0] b;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       clk_en;
  logic [3:0] keyon_op;
  logic [2:0] keyon_ch;
  logic       up_keyon;
  logic [1:0] next_op;
  logic [2:0] next_ch;
  logic       csm;
  logic       overflow_A;
  logic       keyon_I,  kon_edge,  koff_edge;
  logic       keyon_I3, kon_edge3, koff_edge3;

  int   checks;
  int   errors;
  exp_t sb[$];
  logic [2:0] obs;
  logic [2:0] obs3;

  logic [3:0] m_kon  [2][8];
  logic [3:0] m_prev [2][8];
  int         m_st   [2];
  int         m_n    [2];

  jt12_kon_gen dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
    .keyon_op(keyon_op), .keyon_ch(keyon_ch), .up_keyon(up_keyon),
    .next_op(next_op), .next_ch(next_ch),
    .csm(csm), .overflow_A(overflow_A),
    .keyon_I(keyon_I), .kon_edge(kon_edge), .koff_edge(koff_edge)
  );

  jt12_kon_gen #(.NUM_CH(3), .CSM_CH(2), .CSM_EN(1'b1)) dut3 (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
    .keyon_op(keyon_op), .keyon_ch(keyon_ch), .up_keyon(up_keyon),
    .next_op(next_op), .next_ch(next_ch),
    .csm(csm), .overflow_A(overflow_A),
    .keyon_I(keyon_I3), .kon_edge(kon_edge3), .koff_edge(koff_edge3)
  );

  // Free-running clock, 10 ns period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Clear the model the same way reset clears the hardware
  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_st[k] = 0;
      for (int c = 0; c < 8; c++) begin
        m_kon[k][c]  = 4'h0;
        m_prev[k][c] = 4'h0;
      end
    end
  endfunction

  // One enabled cycle of the model for both instances; CSM states are
  // 0 idle, 1 armed, 2 active
  function automatic exp_t model_step(input int ch, input int op, input bit wr,
                                      input int wch, input logic [3:0] wop, input bit ovf);
    exp_t e;
    logic [2:0] r [2];
    for (int k = 0; k < 2; k++) begin
      bit f, cur, p;
      int pop;
      f   = 1'b0;
      cur = 1'b0;
      p   = 1'b0;
      pop = (op == 1) ? 2 : (op == 2) ? 1 : op;
      if (!csm) begin
        m_st[k] = 0;
      end else if (m_st[k] == 0) begin
        if (ovf) m_st[k] = 1;
      end else if (m_st[k] == 1) begin
        if (ch == MODEL_CSM_CH && op == 0) begin
          f = 1'b1;
          m_st[k] = 2;
        end
      end else begin
        f = (ch == MODEL_CSM_CH);
        if (ch == MODEL_CSM_CH && op == 3) m_st[k] = 0;
      end
      if (ch < m_n[k]) begin
        cur = m_kon[k][ch][pop] | f;
        p   = m_prev[k][ch][pop];
        m_prev[k][ch][pop] = cur;
      end
      r[k] = {cur, cur & ~p, ~cur & p};
      if (wr && wch < m_n[k]) m_kon[k][wch] = wop;
    end
    e.a = r[0];
    e.b = r[1];
    return e;
  endfunction

  // Drive one clk_en cycle, queue its expectation, sample outputs after it
  task automatic step(input int ch, input int op, input bit wr, input int wch,
                      input logic [3:0] wop, input bit ovf);
    @(negedge clk);
    next_ch    = 3'(ch);
    next_op    = 2'(op);
    up_keyon   = wr;
    keyon_ch   = 3'(wch);
    keyon_op   = wop;
    overflow_A = ovf;
    clk_en     = 1'b1;
    sb.push_back(model_step(ch, op, wr, wch, wop, ovf));
    @(posedge clk);
    #1;
    obs        = {keyon_I, kon_edge, koff_edge};
    obs3       = {keyon_I3, kon_edge3, koff_edge3};
    clk_en     = 1'b0;
    up_keyon   = 1'b0;
    overflow_A = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    int   nonzero;
    rst_n = 1'b1;
    #2;
    rst_n = 1'b0;
    model_reset();
    sb.delete();
    #1;
    checks++;
    if ({keyon_I, kon_edge, koff_edge, keyon_I3, kon_edge3, koff_edge3} !== 6'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %b%b%b/%b%b%b expected 000/000",
               keyon_I, kon_edge, koff_edge, keyon_I3, kon_edge3, koff_edge3);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    nonzero = 0;
    for (int op = 0; op < 4; op++) begin
      for (int ch = 0; ch < 8; ch++) begin
        step(ch, op, 1'b0, 0, 4'h0, 1'b0);
        e = sb.pop_front();
        checks++;
        if (obs !== e.a || obs3 !== e.b) begin
          errors++;
          $display("[TB] FAIL reset_sweep slot(%0d,%0d): got %b/%b expected %b/%b",
                   ch, op, obs, obs3, e.a, e.b);
        end
        if (obs != 3'b000 || obs3 != 3'b000) nonzero++;
      end
    end
    checks++;
    if (nonzero !== 0) begin
      errors++;
      $display("[TB] FAIL reset_sweep_count: got %0d active slots expected 0", nonzero);
    end
  endtask

  task automatic test_keyon_write();
    exp_t e;
    int   exp_lvl [3] = '{2, 2, 0};
    int   exp_on  [3] = '{2, 0, 0};
    int   exp_off [3] = '{0, 0, 2};
    int   lvl, on_n, off_n;
    for (int p = 0; p < 3; p++) begin
      if (p != 1) begin
        step(7, 3, 1'b1, 1, (p == 0) ? 4'b0101 : 4'b0000, 1'b0);
        e = sb.pop_front();
        checks++;
        if (obs !== e.a || obs3 !== e.b) begin
          errors++;
          $display("[TB] FAIL keyon_carrier pass%0d: got %b/%b expected %b/%b",
                   p, obs, obs3, e.a, e.b);
        end
      end
      lvl = 0; on_n = 0; off_n = 0;
      for (int op = 0; op < 4; op++) begin
        for (int ch = 0; ch < 8; ch++) begin
          step(ch, op, 1'b0, 0, 4'h0, 1'b0);
          e = sb.pop_front();
          checks++;
          if (obs !== e.a || obs3 !== e.b) begin
            errors++;
            $display("[TB] FAIL keyon_sweep pass%0d slot(%0d,%0d): got %b/%b expected %b/%b",
                     p, ch, op, obs, obs3, e.a, e.b);
          end
          if (ch == 1 && obs[2] && op < 2) lvl++;
          if (obs[1]) on_n++;
          if (obs[0]) off_n++;
        end
      end
      checks++;
      if (lvl !== exp_lvl[p] || on_n !== exp_on[p] || off_n !== exp_off[p]) begin
        errors++;
        $display("[TB] FAIL keyon_counts pass%0d: got lvl=%0d on=%0d off=%0d expected lvl=%0d on=%0d off=%0d",
                 p, lvl, on_n, off_n, exp_lvl[p], exp_on[p], exp_off[p]);
      end
    end
  endtask

  task automatic test_invalid_ch();
    exp_t e;
    int   small_active, on_n, off_n;
    small_active = 0;
    for (int p = 0; p < 2; p++) begin
      if (p == 0) begin
        step(7, 3, 1'b1, 3, 4'hF, 1'b0);
      end else begin
        step(7, 3, 1'b1, 3, 4'h0, 1'b0);
        e = sb.pop_front();
        checks++;
        if (obs !== e.a || obs3 !== e.b) begin
          errors++;
          $display("[TB] FAIL invalid_carrier_clear: got %b/%b expected %b/%b", obs, obs3, e.a, e.b);
        end
        step(7, 3, 1'b1, 7, 4'hF, 1'b0);
      end
      e = sb.pop_front();
      checks++;
      if (obs !== e.a || obs3 !== e.b) begin
        errors++;
        $display("[TB] FAIL invalid_carrier pass%0d: got %b/%b expected %b/%b", p, obs, obs3, e.a, e.b);
      end
      on_n = 0; off_n = 0;
      for (int op = 0; op < 4; op++) begin
        for (int ch = 0; ch < 8; ch++) begin
          step(ch, op, 1'b0, 0, 4'h0, 1'b0);
          e = sb.pop_front();
          checks++;
          if (obs !== e.a || obs3 !== e.b) begin
            errors++;
            $display("[TB] FAIL invalid_sweep pass%0d slot(%0d,%0d): got %b/%b expected %b/%b",
                     p, ch, op, obs, obs3, e.a, e.b);
          end
          if (obs3 != 3'b000) small_active++;
          if (ch == 3 && obs[1]) on_n++;
          if (ch == 3 && obs[0]) off_n++;
        end
      end
      checks++;
      if (on_n !== ((p == 0) ? 4 : 0) || off_n !== ((p == 0) ? 0 : 4)) begin
        errors++;
        $display("[TB] FAIL invalid_ch3_main pass%0d: got on=%0d off=%0d expected on=%0d off=%0d",
                 p, on_n, off_n, (p == 0) ? 4 : 0, (p == 0) ? 0 : 4);
      end
    end
    checks++;
    if (small_active !== 0) begin
      errors++;
      $display("[TB] FAIL invalid_small_dut: got %0d active slots expected 0", small_active);
    end
  endtask

  task automatic test_same_slot();
    exp_t e;
    step(0, 0, 1'b1, 0, 4'b0001, 1'b0);
    e = sb.pop_front();
    checks++;
    if (obs !== e.a || obs3 !== e.b || obs !== 3'b000) begin
      errors++;
      $display("[TB] FAIL same_slot_old: got %b/%b expected %b/%b", obs, obs3, e.a, e.b);
    end
    for (int op = 0; op < 4; op++) begin
      for (int ch = 0; ch < 8; ch++) begin
        step(ch, op, 1'b0, 0, 4'h0, 1'b0);
        e = sb.pop_front();
        checks++;
        if (obs !== e.a || obs3 !== e.b) begin
          errors++;
          $display("[TB] FAIL same_slot_sweep slot(%0d,%0d): got %b/%b expected %b/%b",
                   ch, op, obs, obs3, e.a, e.b);
        end
        if (ch == 0 && op == 0) begin
          checks++;
          if (obs !== 3'b110) begin
            errors++;
            $display("[TB] FAIL same_slot_new: got %b expected 110", obs);
          end
        end
      end
    end
  endtask

  task automatic test_hold();
    exp_t e;
    step(0, 0, 1'b0, 0, 4'h0, 1'b0);
    e = sb.pop_front();
    checks++;
    if (obs !== e.a || obs3 !== e.b) begin
      errors++;
      $display("[TB] FAIL hold_setup: got %b/%b expected %b/%b", obs, obs3, e.a, e.b);
    end
    @(negedge clk);
    next_ch  = 3'd1;
    next_op  = 2'd2;
    up_keyon = 1'b1;
    keyon_ch = 3'd0;
    keyon_op = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    up_keyon = 1'b0;
    checks++;
    if ({keyon_I, kon_edge, koff_edge} !== e.a || {keyon_I3, kon_edge3, koff_edge3} !== e.b) begin
      errors++;
      $display("[TB] FAIL hold_outputs: got %b%b%b/%b%b%b expected %b/%b",
               keyon_I, kon_edge, koff_edge, keyon_I3, kon_edge3, koff_edge3, e.a, e.b);
    end
    step(0, 0, 1'b0, 0, 4'h0, 1'b0);
    e = sb.pop_front();
    checks++;
    if (obs !== e.a || obs3 !== e.b) begin
      errors++;
      $display("[TB] FAIL hold_no_write: got %b/%b expected %b/%b", obs, obs3, e.a, e.b);
    end
    step(7, 3, 1'b1, 0, 4'h0, 1'b0);
    e = sb.pop_front();
    checks++;
    if (obs !== e.a || obs3 !== e.b) begin
      errors++;
      $display("[TB] FAIL hold_cleanup: got %b/%b expected %b/%b", obs, obs3, e.a, e.b);
    end
  endtask

  task automatic test_csm_pass();
    exp_t e;
    int   exp_lvl [4] = '{0, 4, 0, 0};
    int   exp_on  [4] = '{0, 4, 0, 0};
    int   exp_off [4] = '{0, 0, 4, 0};
    int   lvl, on_n, off_n;
    bit   ovf;
    csm = 1'b1;
    for (int p = 0; p < 4; p++) begin
      lvl = 0; on_n = 0; off_n = 0;
      for (int op = 0; op < 4; op++) begin
        for (int ch = 0; ch < 8; ch++) begin
          ovf = (p == 0 && ((op == 0 && ch == 4) || (op == 1 && ch == 0) || (op == 2 && ch == 5))) ||
                (p == 1 && op == 1 && ch == 4);
          step(ch, op, 1'b0, 0, 4'h0, ovf);
          e = sb.pop_front();
          checks++;
          if (obs !== e.a || obs3 !== e.b) begin
            errors++;
            $display("[TB] FAIL csm_sweep pass%0d slot(%0d,%0d): got %b/%b expected %b/%b",
                     p, ch, op, obs, obs3, e.a, e.b);
          end
          if (ch == 2 && obs[2]) lvl++;
          if (ch == 2 && obs[1]) on_n++;
          if (ch == 2 && obs[0]) off_n++;
        end
      end
      checks++;
      if (lvl !== exp_lvl[p] || on_n !== exp_on[p] || off_n !== exp_off[p]) begin
        errors++;
        $display("[TB] FAIL csm_counts pass%0d: got lvl=%0d on=%0d off=%0d expected lvl=%0d on=%0d off=%0d",
                 p, lvl, on_n, off_n, exp_lvl[p], exp_on[p], exp_off[p]);
      end
    end
    csm = 1'b0;
  endtask

  task automatic test_csm_drop();
    exp_t e;
    int   lvl, off_n;
    csm = 1'b1;
    step(7, 3, 1'b0, 0, 4'h0, 1'b1);
    e = sb.pop_front();
    checks++;
    if (obs !== e.a || obs3 !== e.b) begin
      errors++;
      $display("[TB] FAIL csm_drop_arm: got %b/%b expected %b/%b", obs, obs3, e.a, e.b);
    end
    for (int p = 0; p < 2; p++) begin
      if (p == 1) csm = 1'b1;
      lvl = 0; off_n = 0;
      for (int op = 0; op < 4; op++) begin
        for (int ch = 0; ch < 8; ch++) begin
          step(ch, op, 1'b0, 0, 4'h0, 1'b0);
          e = sb.pop_front();
          checks++;
          if (obs !== e.a || obs3 !== e.b) begin
            errors++;
            $display("[TB] FAIL csm_drop_sweep pass%0d slot(%0d,%0d): got %b/%b expected %b/%b",
                     p, ch, op, obs, obs3, e.a, e.b);
          end
          if (ch == 2 && obs[2]) lvl++;
          if (ch == 2 && obs[0]) off_n++;
          if (p == 0 && ch == 2 && op == 1) csm = 1'b0;
        end
      end
      checks++;
      if (lvl !== ((p == 0) ? 2 : 0) || off_n !== ((p == 0) ? 0 : 2)) begin
        errors++;
        $display("[TB] FAIL csm_drop_counts pass%0d: got lvl=%0d off=%0d expected lvl=%0d off=%0d",
                 p, lvl, off_n, (p == 0) ? 2 : 0, (p == 0) ? 0 : 2);
      end
    end
    csm = 1'b0;
  endtask

  task automatic test_reset_mid_pass();
    exp_t e;
    int   lvl, on5;
    csm = 1'b1;
    step(7, 3, 1'b1, 5, 4'hF, 1'b1);
    e = sb.pop_front();
    checks++;
    if (obs !== e.a || obs3 !== e.b) begin
      errors++;
      $display("[TB] FAIL rst_mid_arm: got %b/%b expected %b/%b", obs, obs3, e.a, e.b);
    end
    for (int s = 0; s <= 10; s++) begin
      step(s % 8, s / 8, 1'b0, 0, 4'h0, 1'b0);
      e = sb.pop_front();
      checks++;
      if (obs !== e.a || obs3 !== e.b) begin
        errors++;
        $display("[TB] FAIL rst_mid_partial slot(%0d,%0d): got %b/%b expected %b/%b",
                 s % 8, s / 8, obs, obs3, e.a, e.b);
      end
    end
    checks++;
    if (obs !== 3'b110) begin
      errors++;
      $display("[TB] FAIL rst_mid_forced: got %b expected 110", obs);
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    sb.delete();
    #1;
    checks++;
    if ({keyon_I, kon_edge, koff_edge, keyon_I3, kon_edge3, koff_edge3} !== 6'b0) begin
      errors++;
      $display("[TB] FAIL rst_mid_async: got %b%b%b/%b%b%b expected 000/000",
               keyon_I, kon_edge, koff_edge, keyon_I3, kon_edge3, koff_edge3);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(7, 3, 1'b1, 5, 4'b1000, 1'b0);
    e = sb.pop_front();
    checks++;
    if (obs !== e.a || obs3 !== e.b) begin
      errors++;
      $display("[TB] FAIL rst_mid_write: got %b/%b expected %b/%b", obs, obs3, e.a, e.b);
    end
    lvl = 0; on5 = 0;
    for (int op = 0; op < 4; op++) begin
      for (int ch = 0; ch < 8; ch++) begin
        step(ch, op, 1'b0, 0, 4'h0, 1'b0);
        e = sb.pop_front();
        checks++;
        if (obs !== e.a || obs3 !== e.b) begin
          errors++;
          $display("[TB] FAIL rst_mid_sweep slot(%0d,%0d): got %b/%b expected %b/%b",
                   ch, op, obs, obs3, e.a, e.b);
        end
        if (ch == 2 && obs[2]) lvl++;
        if (ch == 5 && obs[1]) on5++;
      end
    end
    checks++;
    if (lvl !== 0 || on5 !== 1) begin
      errors++;
      $display("[TB] FAIL rst_mid_after: got ch2_lvl=%0d ch5_on=%0d expected ch2_lvl=0 ch5_on=1", lvl, on5);
    end
    csm = 1'b0;
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst_n      = 1'b1;
    clk_en     = 1'b0;
    keyon_op   = 4'h0;
    keyon_ch   = 3'd0;
    up_keyon   = 1'b0;
    next_op    = 2'd0;
    next_ch    = 3'd0;
    csm        = 1'b0;
    overflow_A = 1'b0;
    obs        = 3'b000;
    obs3       = 3'b000;
    m_n[0]     = 6;
    m_n[1]     = 3;
    model_reset();
    $display("[TB] jt12_kon_gen bench start");
    test_reset();
    test_keyon_write();
    test_invalid_ch();
    test_same_slot();
    test_hold();
    test_csm_pass();
    test_csm_drop();
    test_reset_mid_pass();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
